// File: rtl/hazard_ctrl.sv
// hazard_ctrl - pipeline hazard and flow-control unit for the 16-bit
// 5-stage processor.
//
// Drives the stall/flush interface of the ID stage and the IF/ID and ID/EX
// pipeline registers. It resolves load-use hazards, taken-branch redirection,
// jumps, multi-cycle floating-point occupancy of EX, and the Stop drain/halt
// sequence. It also produces the EX-stage operand forwarding selects.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   rsD, rtD              source specifiers of the instruction in ID
//   JumpD, StopD          decoded jump / stop in ID
//   rsE, rtE, WriteRegE   source / destination specifiers in EX
//   RegWriteE, MemReadE,
//   FloatingE, PCSrcE     EX control bits (PCSrcE = branch resolved taken)
//   WriteRegM/W,
//   RegWriteM/W           destinations and write enables in MEM / WB
//   stall_IF, stall_IF_ID,
//   flush_IF_ID,
//   stall_ID_EX,
//   flush_ID_EX           pipeline hold / bubble controls (combinational)
//   forwardAE, forwardBE  00 regfile, 10 MEM result, 01 WB result
//   fp_busy               FSM is in FP_BUSY (registered)
//   halted                processor halted (registered)
module hazard_ctrl #(
  parameter int REG_WIDTH    = 4,
  parameter int FP_LATENCY   = 3,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_WIDTH    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_WIDTH-1:0] rsD,
  input  logic [REG_WIDTH-1:0] rtD,
  input  logic                 JumpD,
  input  logic                 StopD,
  input  logic [REG_WIDTH-1:0] rsE,
  input  logic [REG_WIDTH-1:0] rtE,
  input  logic [REG_WIDTH-1:0] WriteRegE,
  input  logic                 RegWriteE,
  input  logic                 MemReadE,
  input  logic                 FloatingE,
  input  logic                 PCSrcE,
  input  logic [REG_WIDTH-1:0] WriteRegM,
  input  logic [REG_WIDTH-1:0] WriteRegW,
  input  logic                 RegWriteM,
  input  logic                 RegWriteW,
  output logic                 stall_IF,
  output logic                 stall_IF_ID,
  output logic                 flush_IF_ID,
  output logic                 stall_ID_EX,
  output logic                 flush_ID_EX,
  output logic [1:0]           forwardAE,
  output logic [1:0]           forwardBE,
  output logic                 fp_busy,
  output logic                 halted
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FP_BUSY = 2'd1,
    DRAIN   = 2'd2,
    HALT    = 2'd3
  } state_t;

  // FP_BUSY lasts FP_LATENCY-2 cycles; together with the triggering RUN
  // cycle that gives FP_LATENCY-1 stall cycles in total.
  localparam logic [CNT_WIDTH-1:0] FP_LOAD    = CNT_WIDTH'(FP_LATENCY - 2);
  localparam logic [CNT_WIDTH-1:0] DRAIN_LOAD = CNT_WIDTH'(DRAIN_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO   = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 fpAck;   // FP op in EX has already been serviced
  logic                 loadUse;
  logic                 fpTrig;

  assign loadUse = MemReadE && RegWriteE &&
                   ((WriteRegE == rsD) || (WriteRegE == rtD));
  assign fpTrig  = FloatingE && !fpAck;

  // Operand forwarding selects; MEM result takes precedence over WB.
  always_comb begin
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    if (rst) begin
      forwardAE = 2'b00;
      forwardBE = 2'b00;
    end else begin
      if (RegWriteM && (WriteRegM == rsE)) begin
        forwardAE = 2'b10;
      end else if (RegWriteW && (WriteRegW == rsE)) begin
        forwardAE = 2'b01;
      end else begin
        forwardAE = 2'b00;
      end
      if (RegWriteM && (WriteRegM == rtE)) begin
        forwardBE = 2'b10;
      end else if (RegWriteW && (WriteRegW == rtE)) begin
        forwardBE = 2'b01;
      end else begin
        forwardBE = 2'b00;
      end
    end
  end

  // Stall/flush decode; same-cycle response to hazards seen in RUN.
  always_comb begin
    stall_IF    = 1'b0;
    stall_IF_ID = 1'b0;
    flush_IF_ID = 1'b0;
    stall_ID_EX = 1'b0;
    flush_ID_EX = 1'b0;
    if (rst) begin
      stall_IF = 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (PCSrcE) begin
            // Wrong-path instructions in IF/ID are discarded outright.
            flush_IF_ID = 1'b1;
            flush_ID_EX = 1'b1;
          end else if (fpTrig) begin
            stall_IF    = 1'b1;
            stall_IF_ID = 1'b1;
            stall_ID_EX = 1'b1;
          end else if (loadUse) begin
            stall_IF    = 1'b1;
            stall_IF_ID = 1'b1;
            flush_ID_EX = 1'b1;
          end else if (StopD) begin
            stall_IF    = 1'b1;
            flush_IF_ID = 1'b1;
          end else if (JumpD) begin
            flush_IF_ID = 1'b1;
          end else begin
            stall_IF = 1'b0;
          end
        end
        FP_BUSY, HALT: begin
          stall_IF    = 1'b1;
          stall_IF_ID = 1'b1;
          stall_ID_EX = 1'b1;
        end
        DRAIN: begin
          stall_IF    = 1'b1;
          flush_IF_ID = 1'b1;
          flush_ID_EX = 1'b1;
        end
        default: begin
          stall_IF = 1'b0;
        end
      endcase
    end
  end

  // Control FSM with occupancy counter, FP acknowledge and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      cnt     <= CNT_ZERO;
      fpAck   <= 1'b0;
      fp_busy <= 1'b0;
      halted  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          fpAck <= 1'b0;
          if (PCSrcE) begin
            state <= RUN;
          end else if (fpTrig) begin
            if (FP_LATENCY > 2) begin
              state   <= FP_BUSY;
              cnt     <= FP_LOAD;
              fp_busy <= 1'b1;
            end else begin
              // Single stall cycle is enough; acknowledge immediately.
              fpAck <= 1'b1;
            end
          end else if (loadUse) begin
            state <= RUN;
          end else if (StopD) begin
            state <= DRAIN;
            cnt   <= DRAIN_LOAD;
          end else begin
            state <= RUN;
          end
        end
        FP_BUSY: begin
          // Leave as the counter reaches zero so the FP instruction still
          // sitting in ID/EX is not serviced a second time.
          if (cnt <= CNT_ONE) begin
            state   <= RUN;
            cnt     <= CNT_ZERO;
            fpAck   <= 1'b1;
            fp_busy <= 1'b0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        DRAIN: begin
          if (cnt == CNT_ZERO) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state   <= RUN;
          cnt     <= CNT_ZERO;
          fp_busy <= 1'b0;
          halted  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (default parameters).
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW;
  logic       JumpD, StopD, RegWriteE, MemReadE, FloatingE, PCSrcE;
  logic       RegWriteM, RegWriteW;
  logic       stall_IF, stall_IF_ID, flush_IF_ID, stall_ID_EX, flush_ID_EX;
  logic [1:0] forwardAE, forwardBE;
  logic       fp_busy, halted;
  logic [6:0] outs;

  int nAssert = 0;
  int nFail   = 0;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .JumpD(JumpD), .StopD(StopD),
    .rsE(rsE), .rtE(rtE), .WriteRegE(WriteRegE),
    .RegWriteE(RegWriteE), .MemReadE(MemReadE), .FloatingE(FloatingE),
    .PCSrcE(PCSrcE),
    .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .stall_IF(stall_IF), .stall_IF_ID(stall_IF_ID), .flush_IF_ID(flush_IF_ID),
    .stall_ID_EX(stall_ID_EX), .flush_ID_EX(flush_ID_EX),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .fp_busy(fp_busy), .halted(halted)
  );

  always #5 clk = ~clk;

  // {stall_IF, stall_IF_ID, flush_IF_ID, stall_ID_EX, flush_ID_EX, fp_busy, halted}
  assign outs = {stall_IF, stall_IF_ID, flush_IF_ID, stall_ID_EX, flush_ID_EX,
                 fp_busy, halted};

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIn();
    rsD = 4'd0; rtD = 4'd0; rsE = 4'd0; rtE = 4'd0;
    WriteRegE = 4'd0; WriteRegM = 4'd0; WriteRegW = 4'd0;
    JumpD = 1'b0; StopD = 1'b0; RegWriteE = 1'b0; MemReadE = 1'b0;
    FloatingE = 1'b0; PCSrcE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
  endtask

  initial begin
    clearIn();
    rst = 1'b1;
    tick();
    // Reset gating: hazards and forwarding matches present while in reset.
    MemReadE = 1'b1; RegWriteE = 1'b1; WriteRegE = 4'd2; rsD = 4'd2;
    RegWriteM = 1'b1; WriteRegM = 4'd0; rsE = 4'd0; StopD = 1'b1;
    tick();
    chk("rst_outs", outs, 7'b0000000);
    chk("rst_fwd", {3'b000, forwardAE, forwardBE}, 7'b0000000);
    clearIn();
    rst = 1'b0;
    tick();
    chk("idle_outs", outs, 7'b0000000);

    // Forwarding
    RegWriteM = 1'b1; WriteRegM = 4'd5; RegWriteW = 1'b1; WriteRegW = 4'd5;
    rsE = 4'd5; rtE = 4'd5; #1;
    chk("fwd_mem", {3'b000, forwardAE, forwardBE}, 7'b0001010);
    RegWriteM = 1'b0; #1;
    chk("fwd_wb", {3'b000, forwardAE, forwardBE}, 7'b0000101);
    rsE = 4'd6; #1;
    chk("fwd_none_a", {3'b000, forwardAE, forwardBE}, 7'b0000001);
    RegWriteW = 1'b0; RegWriteM = 1'b1; WriteRegM = 4'd0; rsE = 4'd0; rtE = 4'd0; #1;
    chk("fwd_r0", {3'b000, forwardAE, forwardBE}, 7'b0001010);
    clearIn();

    // Load-use on rt, then on rs, then no match
    MemReadE = 1'b1; RegWriteE = 1'b1; WriteRegE = 4'd3; rtD = 4'd3; #1;
    chk("lu_rt", outs, 7'b1100100);
    tick();
    MemReadE = 1'b0; RegWriteE = 1'b0; #1;
    chk("lu_bubble", outs, 7'b0000000);
    MemReadE = 1'b1; RegWriteE = 1'b1; rsD = 4'd3; rtD = 4'd7; #1;
    chk("lu_rs", outs, 7'b1100100);
    rsD = 4'd4; rtD = 4'd7; #1;
    chk("lu_nomatch", outs, 7'b0000000);
    tick();

    // Branch beats load-use and Stop
    rtD = 4'd3; StopD = 1'b1; PCSrcE = 1'b1; #1;
    chk("br_prio", outs, 7'b0010100);
    tick();
    clearIn(); #1;
    chk("br_stay_run", outs, 7'b0000000);
    tick();
    chk("br_no_halt", outs, 7'b0000000);

    // Jump
    JumpD = 1'b1; #1;
    chk("jump", outs, 7'b0010000);
    tick();
    clearIn();

    // FP op, then back-to-back FP op
    FloatingE = 1'b1; #1;
    chk("fp_c1", outs, 7'b1101000);
    tick();
    JumpD = 1'b1; #1;
    chk("fp_c2", outs, 7'b1101010);
    tick();
    JumpD = 1'b0; #1;
    chk("fp_release", outs, 7'b0000000);
    tick();
    chk("fp2_c1", outs, 7'b1101000);
    tick();
    chk("fp2_c2", outs, 7'b1101010);
    tick();
    chk("fp2_release", outs, 7'b0000000);
    FloatingE = 1'b0;
    tick();
    chk("fp_after", outs, 7'b0000000);

    // Stop: one RUN cycle + three DRAIN cycles, then HALT
    StopD = 1'b1; #1;
    chk("stop_c0", outs, 7'b1010000);
    tick();
    StopD = 1'b0;
    chk("drain_c1", outs, 7'b1010100);
    tick();
    chk("drain_c2", outs, 7'b1010100);
    tick();
    chk("drain_c3", outs, 7'b1010100);
    tick();
    chk("halt", outs, 7'b1101001);
    PCSrcE = 1'b1; FloatingE = 1'b1;
    tick();
    chk("halt_hold", outs, 7'b1101001);
    clearIn();
    rst = 1'b1; #1;
    chk("halt_in_rst", outs, 7'b0000001);
    tick();
    chk("halt_cleared", outs, 7'b0000000);
    rst = 1'b0;
    tick();
    chk("post_halt_run", outs, 7'b0000000);

    // Reset during FP_BUSY
    FloatingE = 1'b1;
    tick();
    rst = 1'b1; #1;
    chk("rst_fpbusy", outs, 7'b0000010);
    tick();
    chk("rst_fpbusy_run", outs, 7'b0000000);
    rst = 1'b0; FloatingE = 1'b0;
    tick();
    chk("after_rst_fp", outs, 7'b0000000);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
